bcd2bin_seq: RTL and testbench

- Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from any digit that is ≥8.
- Performs the inverse of the project's bin2bcd stage.
- Sits between keypad digit capture and the arithmetic core: decimal keypad entries become binary operands for divisor_restoring_7bits.
- Start/done handshake, invalid-digit and overflow flags.

---
 rtl/bcd2bin_pkg.sv | 31 +++
 rtl/bcd_digit_adj.sv | 24 ++
 rtl/bcd2bin_seq.sv | 148 ++++++++++++++
 tb/tb_bcd2bin_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bcd2bin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd2bin_pkg
// Description : Shared types and constants for the sequential BCD-to-binary
//               converter (state enum, digit-adjust constants, digit check).
// Revision    : 1.0  initial release
// ============================================================================
package bcd2bin_pkg;

  // Converter control states, 2-bit encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CONV = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // A BCD nibble at or above this value after a right shift needs correction
  localparam logic [3:0] BCD_ADJ_THR   = 4'd8;
  // Correction subtracted from such a nibble
  localparam logic [3:0] BCD_ADJ_VAL   = 4'd3;
  // Largest legal decimal digit
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // True when a nibble is not a legal decimal digit
  function automatic logic digit_invalid(input logic [3:0] d);
    return (d > BCD_MAX_DIGIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Reverse double-dabble digit correction. A nibble that is 8 or
//               more after the shift has 3 subtracted; otherwise it passes.
// Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_adj
  import bcd2bin_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Subtract is only taken when din >= 8, so it cannot wrap
  always_comb begin
    dout = din;
    if (din >= BCD_ADJ_THR) begin
      dout = din - BCD_ADJ_VAL;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd2bin_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd2bin_seq
// Description : Sequential BCD-to-binary converter (reverse double-dabble).
//               Start/done handshake, invalid-digit and overflow flags.
//               Optional macro BCD2BIN_SAT_EN: saturate bin on overflow
//               instead of truncating.
// Revision    : 1.0  initial release
// ============================================================================
module bcd2bin_seq
  import bcd2bin_pkg::*;
#(
  parameter int ND = 3,
  parameter int NB = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4*ND-1:0] bcd,
  output logic [NB-1:0]   bin,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int          W    = 4 * ND;
  localparam int          CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [2*W-1:0]  r_sr;
  logic [CW-1:0]   r_cnt;
  logic            r_inv;
  logic [2*W-1:0]  w_shift;
  logic [W-1:0]    w_adj;
  logic [2*W-1:0]  w_conv;
  logic [W-1:0]    w_raw;
  logic            w_inv;
  logic            w_ovf;

  assign w_shift = r_sr >> 1;
  assign w_conv  = {w_adj, w_shift[W-1:0]};
  assign w_raw   = r_sr[W-1:0];

  // One correction unit per BCD digit of the upper field
  generate
    for (genvar gi = 0; gi < ND; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (w_shift[W + 4*gi +: 4]),
        .dout (w_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Flag any latched digit that is not 0..9
  always_comb begin
    w_inv = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if (digit_invalid(r_sr[W + 4*i +: 4])) begin
        w_inv = 1'b1;
      end
    end
  end

  // Result does not fit in NB bits
  always_comb begin
    w_ovf = ((w_raw >> NB) != '0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_LOAD;
      S_LOAD: w_state_next = w_inv ? S_FIN : S_CONV;
      S_CONV: if (r_cnt == LAST) w_state_next = S_FIN;
      S_FIN:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Busy covers LOAD and CONV; it drops in the FIN cycle
  always_comb begin
    busy = 1'b0;
    if ((r_state == S_LOAD) || (r_state == S_CONV)) begin
      busy = 1'b1;
    end
  end

  // Datapath: latch, iterate, and register the result with a done pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_inv <= 1'b0;
      bin   <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr <= {bcd, {W{1'b0}}};
          end
        end
        S_LOAD: begin
          r_inv <= w_inv;
          r_cnt <= '0;
        end
        S_CONV: begin
          r_sr  <= w_conv;
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIN: begin
          done <= 1'b1;
          if (r_inv) begin
            bin <= '0;
            err <= 1'b1;
          end else if (w_ovf) begin
            err <= 1'b1;
`ifdef BCD2BIN_SAT_EN
            bin <= {NB{1'b1}};
`else
            bin <= w_raw[NB-1:0];
`endif
          end else begin
            err <= 1'b0;
            bin <= w_raw[NB-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd2bin_seq
// Description : Self-checking bench for bcd2bin_seq with a decimal reference
//               model (directed cases plus random digit strings).
// Revision    : 1.0  initial release
// ============================================================================
module tb_bcd2bin_seq;

  localparam int ND = 3;
  localparam int NB = 7;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic [11:0] bcd   = '0;
  logic [6:0]  bin;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd2bin_seq #(.ND(ND), .NB(NB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Decimal reference: digit validity, value, overflow handling, latency
  task automatic ref_model(input logic [11:0] v, output int lat, output int eb, output int ee);
    int r;
    bit bad;
    r   = 0;
    bad = 1'b0;
    for (int i = ND - 1; i >= 0; i--) begin
      int d;
      d = int'(v >> (4 * i)) & 15;
      if (d > 9) bad = 1'b1;
      r = r * 10 + d;
    end
    if (bad) begin
      lat = 2;
      eb  = 0;
      ee  = 1;
    end else begin
      lat = 4 * ND + 2;
      if (r >= (1 << NB)) begin
        ee = 1;
`ifdef BCD2BIN_SAT_EN
        eb = (1 << NB) - 1;
`else
        eb = r % (1 << NB);
`endif
      end else begin
        ee = 0;
        eb = r;
      end
    end
  endtask

  // One request; optional extra start pulse while busy, optional mid-run reset
  task automatic run(input string name, input logic [11:0] v, input int extra_start, input int rst_cycle);
    int lat, eb, ee;
    int ndone, first, busy_bad;
    logic [6:0] bin_at;
    logic       err_at;
    ndone    = 0;
    first    = -1;
    busy_bad = 0;
    bin_at   = '0;
    err_at   = 1'b0;
    ref_model(v, lat, eb, ee);
    @(negedge clk);
    bcd   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, ":busy_acc"}, 32'(busy), 1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = (k == extra_start);
      bcd   = 12'($urandom);
      if (rst_cycle > 0 && k == rst_cycle)     rst = 1'b0;
      if (rst_cycle > 0 && k == rst_cycle + 2) rst = 1'b1;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) begin
          first  = k;
          bin_at = bin;
          err_at = err;
        end
      end
      if (rst_cycle == 0 && first < 0 && busy !== (k < lat - 1)) busy_bad++;
      if (rst_cycle > 0 && k == rst_cycle) begin
        check({name, ":rst_bin"},  32'(bin),  0);
        check({name, ":rst_busy"}, 32'(busy), 0);
        check({name, ":rst_done"}, 32'(done), 0);
        check({name, ":rst_err"},  32'(err),  0);
      end
    end
    start = 1'b0;
    if (rst_cycle > 0) begin
      check({name, ":no_done"}, 32'(ndone), 0);
    end else begin
      check({name, ":done_cnt"}, 32'(ndone),  1);
      check({name, ":latency"},  32'(first),  32'(lat));
      check({name, ":bin"},      32'(bin_at), 32'(eb));
      check({name, ":err"},      32'(err_at), 32'(ee));
      check({name, ":busy"},     32'(busy_bad), 0);
      check({name, ":bin_hold"}, 32'(bin),    32'(eb));
    end
  endtask

  initial begin
    logic [11:0] v;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset:bin",  32'(bin),  0);
    check("reset:busy", 32'(busy), 0);
    check("reset:done", 32'(done), 0);
    check("reset:err",  32'(err),  0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases
    run("v127",   12'h127, 0, 0);
    run("v099",   12'h099, 0, 0);
    run("v000",   12'h000, 0, 0);
    run("ovf128", 12'h128, 0, 0);
    run("ovf999", 12'h999, 0, 0);
    run("inv1A3", 12'h1A3, 0, 0);
    run("v042",   12'h042, 0, 0);
    run("invF00", 12'hF00, 0, 0);
    run("dblst",  12'h127, 5, 0);
    run("rst050", 12'h050, 0, 6);
    run("v050",   12'h050, 0, 0);

    // Random digit strings, mostly legal with occasional bad nibbles
    for (int n = 0; n < 24; n++) begin
      v = '0;
      for (int i = 0; i < ND; i++) begin
        int d;
        if ($urandom_range(0, 7) == 0) d = int'($urandom_range(10, 15));
        else                           d = int'($urandom_range(0, 9));
        v = (v << 4) | 12'(d);
      end
      run("rand", v, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
